inv_park: RTL



---
 rtl/inv_park.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/inv_park.sv
// Inverse Park transform: rotating D/Q to stationary alpha/beta.
// One shared signed multiplier over four cycles, rounded and saturated.
module inv_park #(
  parameter int D_WIDTH = 18,
  parameter int Q_BITS  = 15
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic signed [D_WIDTH-1:0] d_in,
  input  logic signed [D_WIDTH-1:0] q_in,
  input  logic signed [D_WIDTH-1:0] sin,
  input  logic signed [D_WIDTH-1:0] cos,
  input  logic                      start,
  output logic signed [D_WIDTH-1:0] alpha,
  output logic signed [D_WIDTH-1:0] beta,
  output logic                      busy,
  output logic                      done,
  output logic                      sat
);

  localparam int PW = 2 * D_WIDTH;
  localparam int AW = PW + 1;

  localparam logic signed [AW-1:0] HALF =
    AW'(1) <<< (Q_BITS - 1);
  localparam logic signed [AW-1:0] MAXV =
    AW'((64'sd1 <<< (D_WIDTH - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [2:0] {
    IDLE, M0, M1, M2, M3, FIN
  } state_t;

  state_t state;

  logic signed [D_WIDTH-1:0] d_r, q_r, s_r, c_r;
  logic signed [D_WIDTH-1:0] ma, mb;
  logic signed [PW-1:0]      prod;
  logic signed [AW-1:0]      prod_x;
  logic signed [AW-1:0]      acc_a, acc_b;
  logic signed [AW-1:0]      ra, rb;
  logic signed [D_WIDTH-1:0] alpha_n, beta_n;
  logic                      clip_a, clip_b;

  // Select multiplier operands for the current product term
  always_comb begin
    ma = d_r;
    mb = c_r;
    case (state)
      M1:      begin ma = q_r; mb = s_r; end
      M2:      begin ma = d_r; mb = s_r; end
      M3:      begin ma = q_r; mb = c_r; end
      default: begin ma = d_r; mb = c_r; end
    endcase
  end

  assign prod   = ma * mb;
  assign prod_x = {prod[PW-1], prod};

  // Round half-up, drop fraction, clamp to the output range
  always_comb begin
    ra      = (acc_a + HALF) >>> Q_BITS;
    rb      = (acc_b + HALF) >>> Q_BITS;
    clip_a  = 1'b0;
    clip_b  = 1'b0;
    alpha_n = ra[D_WIDTH-1:0];
    beta_n  = rb[D_WIDTH-1:0];
    if (ra > MAXV) begin
      alpha_n = MAXV[D_WIDTH-1:0];
      clip_a  = 1'b1;
    end else if (ra < MINV) begin
      alpha_n = MINV[D_WIDTH-1:0];
      clip_a  = 1'b1;
    end
    if (rb > MAXV) begin
      beta_n = MAXV[D_WIDTH-1:0];
      clip_b = 1'b1;
    end else if (rb < MINV) begin
      beta_n = MINV[D_WIDTH-1:0];
      clip_b = 1'b1;
    end
  end

  // Sequencer: latch, four multiply-accumulate steps, publish
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      d_r   <= '0;
      q_r   <= '0;
      s_r   <= '0;
      c_r   <= '0;
      acc_a <= '0;
      acc_b <= '0;
      alpha <= '0;
      beta  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sat   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d_r   <= d_in;
            q_r   <= q_in;
            s_r   <= sin;
            c_r   <= cos;
            busy  <= 1'b1;
            state <= M0;
          end
        end
        M0: begin
          acc_a <= prod_x;
          state <= M1;
        end
        M1: begin
          acc_a <= acc_a - prod_x;
          state <= M2;
        end
        M2: begin
          acc_b <= prod_x;
          state <= M3;
        end
        M3: begin
          acc_b <= acc_b + prod_x;
          state <= FIN;
        end
        FIN: begin
          alpha <= alpha_n;
          beta  <= beta_n;
          sat   <= clip_a | clip_b;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
